// File: rtl/nn_alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and stage states.
// Used by the ALU stage and by the decoder that drives its opcode.
package nn_alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned FLAGS_W = 4;

  // Bit positions inside flags = {err, ovf, neg, zero}
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_ERR  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_SLT = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Codes above MUL are reserved and raise err
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_MUL);
  endfunction

endpackage

// File: rtl/alu_stage_if.sv
// Valid/ready operation and result channels of the ALU stage.
// The issuing side (decoder) uses master; the stage uses slave.
interface alu_stage_if
  import nn_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic [FLAGS_W-1:0]  flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH
// cycles after start; product holds the low WIDTH bits of a*b once done pulses.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;

  // Operands load on start; iteration i adds (a << i) when b[i] is set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        cnt    <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc;

endmodule

// File: rtl/alu_stage.sv
// Single-issue ALU pipeline stage with valid/ready handshakes; single-cycle
// ops complete on the accept edge, MUL runs on the iterative multiplier.
module alu_stage
  import nn_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input logic        clk,
  input logic        rst_n,
  alu_stage_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;

  alu_state_e         state_q;
  alu_state_e         state_d;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_d;
  logic [FLAGS_W-1:0] flags_q;
  logic [FLAGS_W-1:0] flags_d;
  logic               out_valid_q;
  logic               out_valid_d;

  logic [WIDTH-1:0]   alu_res;
  logic [FLAGS_W-1:0] alu_flags;
  logic [FLAGS_W-1:0] mul_flags;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     shamt;
  logic               ovf;
  logic               err;

  logic               in_ready_c;
  logic               accept_c;
  logic               mul_start_c;
  logic               mul_busy;
  logic               mul_done;
  logic [WIDTH-1:0]   product;

  assign in_ready_c = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;

  // Single-cycle datapath; MUL results come from the multiplier instead
  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    shamt   = bus.b[SHW-1:0];
    alu_res = '0;
    ovf     = 1'b0;
    err     = !is_legal_op(bus.op);
    case (bus.op)
      OP_ADD: begin
        alu_res = sum;
        ovf     = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        ovf     = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      default: alu_res = '0;
    endcase
    alu_flags            = '0;
    alu_flags[FLAG_ZERO] = (alu_res == '0);
    alu_flags[FLAG_NEG]  = alu_res[MSB];
    alu_flags[FLAG_OVF]  = ovf;
    alu_flags[FLAG_ERR]  = err;
  end

  always_comb begin
    mul_flags            = '0;
    mul_flags[FLAG_ZERO] = (product == '0);
    mul_flags[FLAG_NEG]  = product[MSB];
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mul_start_c = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (bus.op == OP_MUL) begin
            state_d     = ST_MUL;
            mul_start_c = 1'b1;
          end else begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_IDLE;
          result_d    = product;
          flags_d     = mul_flags;
          out_valid_d = 1'b1;
        end else if (!mul_busy) begin
          // Multiplier idle without a result: never strand the stage
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_c),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule
